// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped, write-back, write-allocate cache controller.
// 8 lines x 4 bytes, 11-bit byte address {tag[5:0], index[2:0], offset[1:0]}.
// Backing RAM has one cycle of read latency and takes one byte per cycle.
// Optional macro CACHE_STATS_EN adds saturating hit_cnt/miss_cnt outputs.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for cpu_req; request is latched on the edge it is seen
// COMPARE   | tag check; a hit completes with cpu_ready, a miss picks a path
// WRITEBACK | 4 beats streaming the dirty victim line out to RAM
// ALLOCATE  | 4 address beats plus one trailing capture cycle filling the line
`timescale 1ns/1ps
module cache_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [10:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ready,
  output logic [10:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_wr,
  input  logic [7:0]  mem_dout
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
`endif
);

  localparam int OFFSET_BITS = 2;
  localparam int INDEX_BITS  = 3;
  localparam int TAG_BITS    = 6;
  localparam int LINES       = 1 << INDEX_BITS;
  localparam int LINE_BYTES  = 1 << OFFSET_BITS;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

  state_t state, state_next;

  logic                   req_we;
  logic [10:0]            req_addr;
  logic [7:0]             req_wdata;
  logic [LINES-1:0]       valid;
  logic [LINES-1:0]       dirty;
  logic [TAG_BITS-1:0]    tag_mem  [LINES];
  logic [7:0]             data_mem [LINES][LINE_BYTES];
  // Beats remaining in the current burst: 3..0 for WRITEBACK, 4..0 for ALLOCATE.
  logic [2:0]             beat_left;

  logic [TAG_BITS-1:0]    req_tag;
  logic [INDEX_BITS-1:0]  req_idx;
  logic [OFFSET_BITS-1:0] req_off;
  logic                   hit;
  logic [1:0]             wb_beat;
  logic [2:0]             al_beat_full;
  logic [1:0]             al_beat;
  logic [1:0]             cap_beat;

  assign req_tag      = req_addr[10:5];
  assign req_idx      = req_addr[4:2];
  assign req_off      = req_addr[1:0];
  assign hit          = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  // Counting down 3..0 maps to ascending beats 0..3.
  assign wb_beat      = ~beat_left[1:0];
  assign al_beat_full = 3'd4 - beat_left;
  assign al_beat      = al_beat_full[1:0];
  // RAM data lags the address by one cycle, so the byte captured now is one beat behind.
  assign cap_beat     = ~beat_left[1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode and combinational outputs; everything forced low while reset is high.
  always_comb begin
    state_next = state;
    cpu_ready  = 1'b0;
    cpu_rdata  = 8'h00;
    mem_wr     = 1'b0;
    mem_addr   = 11'h000;
    mem_din    = 8'h00;
    case (state)
      IDLE: begin
        if (cpu_req) state_next = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          cpu_ready  = 1'b1;
          cpu_rdata  = data_mem[req_idx][req_off];
          state_next = IDLE;
        end else if (dirty[req_idx]) begin
          state_next = WRITEBACK;
        end else begin
          state_next = ALLOCATE;
        end
      end
      WRITEBACK: begin
        mem_wr   = 1'b1;
        mem_addr = {tag_mem[req_idx], req_idx, wb_beat};
        mem_din  = data_mem[req_idx][wb_beat];
        if (beat_left == 3'd0) state_next = ALLOCATE;
      end
      ALLOCATE: begin
        mem_addr = {req_tag, req_idx, al_beat};
        if (beat_left == 3'd0) state_next = COMPARE;
      end
      default: state_next = IDLE;
    endcase
    if (reset) begin
      cpu_ready = 1'b0;
      cpu_rdata = 8'h00;
      mem_wr    = 1'b0;
      mem_addr  = 11'h000;
      mem_din   = 8'h00;
    end
  end

  // Request latch, line metadata, data array and burst counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid     <= '0;
      dirty     <= '0;
      beat_left <= 3'd0;
      req_we    <= 1'b0;
      req_addr  <= 11'h000;
      req_wdata <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            req_we    <= cpu_we;
            req_addr  <= cpu_addr;
            req_wdata <= cpu_wdata;
          end
        end
        COMPARE: begin
          if (hit) begin
            if (req_we) begin
              data_mem[req_idx][req_off] <= req_wdata;
              dirty[req_idx]             <= 1'b1;
            end
          end else if (dirty[req_idx]) begin
            beat_left <= 3'd3;
          end else begin
            beat_left <= 3'd4;
          end
        end
        WRITEBACK: begin
          if (beat_left == 3'd0) beat_left <= 3'd4;
          else                   beat_left <= beat_left - 3'd1;
        end
        ALLOCATE: begin
          if (!beat_left[2]) data_mem[req_idx][cap_beat] <= mem_dout;
          if (beat_left == 3'd0) begin
            tag_mem[req_idx] <= req_tag;
            valid[req_idx]   <= 1'b1;
            dirty[req_idx]   <= 1'b0;
          end else begin
            beat_left <= beat_left - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  // Marks the COMPARE that follows a refill so it is not counted a second time.
  logic refill;

  // Refill marker: set as ALLOCATE completes, cleared when a new request is latched.
  always_ff @(posedge clk) begin
    if (reset) begin
      refill <= 1'b0;
    end else if (state == IDLE && cpu_req) begin
      refill <= 1'b0;
    end else if (state == ALLOCATE && beat_left == 3'd0) begin
      refill <= 1'b1;
    end
  end

  // Saturating hit/miss counters, one count per request on its first COMPARE.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt  <= 16'h0000;
      miss_cnt <= 16'h0000;
    end else if (state == COMPARE && !refill) begin
      if (hit) begin
        if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
      end else begin
        if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Testbench for cache_ctrl: directed scenarios plus randomized accesses checked
// against a cache-policy reference model and a flat CPU-view memory image.
`timescale 1ns/1ps
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [10:0] cpu_addr = 11'h000;
  logic [7:0]  cpu_wdata = 8'h00;
  logic [7:0]  cpu_rdata;
  logic        cpu_ready;
  logic [10:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_wr;
  logic [7:0]  mem_dout = 8'h00;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  ram     [2048];
  logic [7:0]  ref_mem [2048];
  logic        m_valid [8];
  logic        m_dirty [8];
  logic [5:0]  m_tag   [8];

  int          wr_n;
  logic [10:0] wr_addr [16];
  logic [7:0]  wr_data [16];
  logic [10:0] tr_addr [32];

  int          exp_nwb;
  logic [10:0] exp_wb_addr [4];
  logic [7:0]  exp_wb_data [4];

  cache_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_wr    (mem_wr),
    .mem_dout  (mem_dout)
`ifdef CACHE_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Backing RAM: registered read, byte write on mem_wr.
  always @(posedge clk) begin
    mem_dout <= ram[mem_addr];
    if (mem_wr) ram[mem_addr] = mem_din;
  end

  // Reference model: policy-level cache (valid/dirty/tag per line) over a CPU-view image.
  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    for (int i = 0; i < 2048; i++) ref_mem[i] = ram[i];
  endtask

  task automatic model_access(input logic we, input logic [10:0] addr, input logic [7:0] wd,
                              output int lat, output logic [7:0] rd);
    int idx;
    logic [5:0] tg;
    idx = int'(addr[4:2]);
    tg  = addr[10:5];
    exp_nwb = 0;
    if (m_valid[idx] && m_tag[idx] == tg) begin
      lat = 1;
    end else begin
      if (m_valid[idx] && m_dirty[idx]) begin
        lat = 11;
        exp_nwb = 4;
        for (int b = 0; b < 4; b++) begin
          exp_wb_addr[b] = {m_tag[idx], addr[4:2], 2'(b)};
          exp_wb_data[b] = ref_mem[{m_tag[idx], addr[4:2], 2'(b)}];
        end
      end else begin
        lat = 7;
      end
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_dirty[idx] = 1'b0;
    end
    if (we) begin
      ref_mem[addr] = wd;
      m_dirty[idx]  = 1'b1;
    end
    rd = ref_mem[addr];
  endtask

  // Issue one request from IDLE, record RAM traffic, return latency (-1 on timeout).
  task automatic do_access(input logic we, input logic [10:0] addr, input logic [7:0] wd,
                           output int lat, output logic [7:0] rd);
    wr_n = 0;
    lat  = -1;
    rd   = 8'h00;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    @(posedge clk);
    #1;
    cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_addr = 11'($urandom); cpu_wdata = 8'($urandom);
    for (int c = 1; c < 32; c++) begin
      @(negedge clk);
      tr_addr[c] = mem_addr;
      if (mem_wr) begin
        if (wr_n < 16) begin
          wr_addr[wr_n] = mem_addr;
          wr_data[wr_n] = mem_din;
        end
        wr_n++;
      end
      if (cpu_ready) begin
        lat = c;
        rd  = cpu_rdata;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2048; i++) ram[i] = 8'($urandom);
    ram[0] = 8'h01; ram[1] = 8'h02; ram[2] = 8'h03; ram[3] = 8'h04;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b want 0", cpu_ready); end
    n_checks++; if (cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_rdata got %h want 00", cpu_rdata); end
    n_checks++; if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL rst_mem_wr got %b want 0", mem_wr); end
    n_checks++; if (mem_addr !== 11'h000) begin n_fail++; $display("FAIL rst_mem_addr got %h want 000", mem_addr); end
    n_checks++; if (mem_din !== 8'h00) begin n_fail++; $display("FAIL rst_mem_din got %h want 00", mem_din); end
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (cpu_ready !== 1'b0 || mem_wr !== 1'b0) begin n_fail++;
      $display("FAIL post_rst_idle got ready=%b wr=%b want 0 0", cpu_ready, mem_wr); end
    model_reset();
  endtask

  task automatic test_clean_miss();
    int lat, el; logic [7:0] rd, er;
    model_access(1'b0, 11'h003, 8'h00, el, er);
    do_access(1'b0, 11'h003, 8'h00, lat, rd);
    n_checks++; if (lat !== 7) begin n_fail++; $display("FAIL clean_miss_lat got %0d want 7", lat); end
    n_checks++; if (rd !== 8'h04) begin n_fail++; $display("FAIL clean_miss_rdata got %h want 04", rd); end
    n_checks++; if (wr_n !== 0) begin n_fail++; $display("FAIL clean_miss_wr got %0d writes want 0", wr_n); end
    for (int b = 0; b < 4; b++) begin
      n_checks++;
      if (tr_addr[b+2] !== 11'(b)) begin n_fail++;
        $display("FAIL clean_miss_addr beat %0d got %h want %h", b, tr_addr[b+2], 11'(b)); end
    end
  endtask

  task automatic test_hit();
    int lat, el; logic [7:0] rd, er;
    model_access(1'b0, 11'h001, 8'h00, el, er);
    do_access(1'b0, 11'h001, 8'h00, lat, rd);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL hit_lat got %0d want 1", lat); end
    n_checks++; if (rd !== 8'h02) begin n_fail++; $display("FAIL hit_rdata got %h want 02", rd); end
    n_checks++; if (wr_n !== 0) begin n_fail++; $display("FAIL hit_wr got %0d writes want 0", wr_n); end
  endtask

  task automatic test_dirty_miss();
    int lat, el; logic [7:0] rd, er;
    logic [7:0] wb_exp [4];
    wb_exp[0] = 8'h01; wb_exp[1] = 8'h02; wb_exp[2] = 8'h03; wb_exp[3] = 8'h09;
    model_access(1'b1, 11'h003, 8'h09, el, er);
    do_access(1'b1, 11'h003, 8'h09, lat, rd);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL write_hit_lat got %0d want 1", lat); end
    model_access(1'b0, 11'h403, 8'h00, el, er);
    do_access(1'b0, 11'h403, 8'h00, lat, rd);
    n_checks++; if (lat !== 11) begin n_fail++; $display("FAIL dirty_miss_lat got %0d want 11", lat); end
    n_checks++; if (rd !== er) begin n_fail++; $display("FAIL dirty_miss_rdata got %h want %h", rd, er); end
    n_checks++; if (wr_n !== 4) begin n_fail++; $display("FAIL dirty_miss_wr_count got %0d want 4", wr_n); end
    for (int b = 0; b < 4; b++) begin
      n_checks++;
      if (wr_addr[b] !== 11'(b) || wr_data[b] !== wb_exp[b]) begin n_fail++;
        $display("FAIL dirty_miss_wb beat %0d got %h:%h want %h:%h", b, wr_addr[b], wr_data[b], 11'(b), wb_exp[b]); end
    end
    for (int b = 0; b < 4; b++) begin
      n_checks++;
      if (tr_addr[b+6] !== 11'h400 + 11'(b)) begin n_fail++;
        $display("FAIL dirty_miss_alloc_addr beat %0d got %h want %h", b, tr_addr[b+6], 11'h400 + 11'(b)); end
    end
  endtask

  task automatic test_stats();
`ifdef CACHE_STATS_EN
    n_checks++; if (hit_cnt !== 16'd2) begin n_fail++; $display("FAIL hit_cnt got %0d want 2", hit_cnt); end
    n_checks++; if (miss_cnt !== 16'd2) begin n_fail++; $display("FAIL miss_cnt got %0d want 2", miss_cnt); end
`endif
  endtask

  task automatic test_reset_abort();
    int lat, el, seen_ready, seen_wr; logic [7:0] rd, er;
    seen_ready = 0; seen_wr = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h2A8; cpu_wdata = 8'h00;
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (cpu_ready) seen_ready++;
      if (mem_wr) seen_wr++;
      if (c == 3) reset = 1'b1;
      if (c == 4) reset = 1'b0;
    end
    n_checks++; if (seen_ready !== 0) begin n_fail++; $display("FAIL abort_ready got %0d pulses want 0", seen_ready); end
    n_checks++; if (seen_wr !== 0) begin n_fail++; $display("FAIL abort_mem_wr got %0d want 0", seen_wr); end
`ifdef CACHE_STATS_EN
    n_checks++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin n_fail++;
      $display("FAIL abort_stats_clear got %0d/%0d want 0/0", hit_cnt, miss_cnt); end
`endif
    model_reset();
    model_access(1'b0, 11'h2A8, 8'h00, el, er);
    do_access(1'b0, 11'h2A8, 8'h00, lat, rd);
    n_checks++; if (lat !== 7) begin n_fail++; $display("FAIL after_abort_lat got %0d want 7", lat); end
    n_checks++; if (rd !== er) begin n_fail++; $display("FAIL after_abort_rdata got %h want %h", rd, er); end
  endtask

  task automatic test_write_miss();
    int lat, el; logic [7:0] rd, er;
    model_access(1'b1, 11'h105, 8'hA5, el, er);
    do_access(1'b1, 11'h105, 8'hA5, lat, rd);
    n_checks++; if (lat !== 7) begin n_fail++; $display("FAIL write_miss_lat got %0d want 7", lat); end
    model_access(1'b0, 11'h105, 8'h00, el, er);
    do_access(1'b0, 11'h105, 8'h00, lat, rd);
    n_checks++; if (lat !== 1 || rd !== 8'hA5) begin n_fail++;
      $display("FAIL write_miss_readback got lat=%0d data=%h want lat=1 data=a5", lat, rd); end
    model_access(1'b0, 11'h505, 8'h00, el, er);
    do_access(1'b0, 11'h505, 8'h00, lat, rd);
    n_checks++; if (lat !== 11) begin n_fail++; $display("FAIL conflict_lat got %0d want 11", lat); end
    n_checks++; if (wr_n !== 4 || wr_addr[1] !== 11'h105 || wr_data[1] !== 8'hA5) begin n_fail++;
      $display("FAIL conflict_wb got n=%0d %h:%h want n=4 105:a5", wr_n, wr_addr[1], wr_data[1]); end
    for (int b = 0; b < 4; b++) begin
      n_checks++;
      if (wr_addr[b] !== exp_wb_addr[b] || wr_data[b] !== exp_wb_data[b]) begin n_fail++;
        $display("FAIL conflict_wb beat %0d got %h:%h want %h:%h", b, wr_addr[b], wr_data[b], exp_wb_addr[b], exp_wb_data[b]); end
    end
  endtask

  task automatic test_random();
    int lat, el, bad; logic [7:0] rd, er, wd; logic we; logic [10:0] a;
    logic [5:0] tags [4];
    tags[0] = 6'h00; tags[1] = 6'h20; tags[2] = 6'h08; tags[3] = 6'h3F;
    for (int n = 0; n < 60; n++) begin
      we = 1'($urandom);
      wd = 8'($urandom);
      a  = {tags[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 2'($urandom)};
      model_access(we, a, wd, el, er);
      do_access(we, a, wd, lat, rd);
      n_checks++; if (lat !== el) begin n_fail++; $display("FAIL rand_lat addr %h got %0d want %0d", a, lat, el); end
      if (!we) begin
        n_checks++; if (rd !== er) begin n_fail++; $display("FAIL rand_rdata addr %h got %h want %h", a, rd, er); end
      end
      bad = (wr_n != exp_nwb) ? 1 : 0;
      for (int b = 0; b < exp_nwb && b < wr_n; b++)
        if (wr_addr[b] !== exp_wb_addr[b] || wr_data[b] !== exp_wb_data[b]) bad = 1;
      n_checks++; if (bad != 0) begin n_fail++;
        $display("FAIL rand_wb addr %h got %0d writes want %0d (or data differs)", a, wr_n, exp_nwb); end
    end
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_hit();
    test_dirty_miss();
    test_stats();
    test_reset_abort();
    test_write_miss();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
